uart_rx_fifo: RTL and testbench

Parametrised UART receiver: the next generation of the existing `uart_rx`, with configurable character width, parity, stop-bit count, error detection and a receive FIFO behind a ready/valid port. It sits between the external RX pin and the core's memory-mapped peripheral logic. It absorbs bursts of characters so that software polling latency does not cause lost bytes, and it reports parity, framing and overrun errors.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_rx_fifo.sv | 155 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: parity modes, receiver states and the
// {ferr, perr, data} word stored in the receive FIFO.
package uart_pkg;

  localparam int MAX_DATA_BITS = 8;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Data field is sized for the widest character; narrower characters are zero-extended.
  typedef struct packed {
    logic                     ferr;
    logic                     perr;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_word_t;

  function automatic logic parity_error(parity_e mode, logic rx_bit, logic [MAX_DATA_BITS-1:0] data);
    case (mode)
      PAR_EVEN: return rx_bit != (^data);
      PAR_ODD:  return rx_bit != (~^data);
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, level count and registered
// show-ahead head output.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      w_rptr_next;
  logic             w_empty;
  logic             w_full;
  logic             w_wr;
  logic             w_rd;

  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_rd        = i_rd_en && !w_empty;
  // A pop frees the slot the simultaneous push needs, so a full FIFO still accepts it.
  assign w_wr        = i_wr_en && (!w_full || w_rd);
  assign w_rptr_next = w_rd ? (r_rptr + PTR_ONE) : r_rptr;

  assign o_overflow  = i_wr_en && w_full && !w_rd;
  assign o_valid     = !w_empty;
  assign o_level     = r_wptr - r_rptr;
  assign o_rd_data   = r_rd_data;

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      r_rptr <= w_rptr_next;
      // Bypass the RAM when the new head is the slot being written this cycle.
      if (w_wr || w_rd) begin
        r_rd_data <= (w_wr && (w_rptr_next == r_wptr)) ? i_wr_data : r_mem[w_rptr_next[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing, parity/framing/overrun detection and
// a show-ahead receive FIFO behind a ready/valid port.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CCS_PER_BIT = 217,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rx_data_i,
  output logic [DATA_BITS-1:0]          rx_byte_o,
  output logic                          rx_perr_o,
  output logic                          rx_ferr_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level_o,
  output logic                          overrun_o,
  input  logic                          ovr_clr_i
);
  localparam int               CNT_W    = $clog2(CCS_PER_BIT);
  localparam parity_e          PAR_MODE = parity_e'(PARITY);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CCS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CCS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]           r_sync;
  rx_state_e            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [2:0]           r_idx;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_overrun;
  logic                 w_rxs;
  logic                 w_tick;
  logic                 w_push;
  logic                 w_overflow;
  rx_word_t             w_word;
  rx_word_t             w_head;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx_data_i};
    end
  end

  assign w_rxs  = r_sync[1];
  assign w_tick = (r_cnt == CNT_FULL);
  // The last stop sample is the push point; ferr folds in the sample taken this cycle.
  assign w_push = (r_state == ST_STOP) && w_tick && (r_idx == 3'(STOP_BITS - 1));

  always_comb begin
    w_word                       = '0;
    w_word.ferr                  = r_ferr | ~w_rxs;
    w_word.perr                  = r_perr;
    w_word.data[DATA_BITS-1:0]   = r_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (!w_rxs) r_state <= ST_START;
        end
        ST_START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_state <= w_rxs ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_cnt         <= '0;
            r_data[r_idx] <= w_rxs;
            r_idx         <= r_idx + 3'd1;
            if (r_idx == 3'(DATA_BITS - 1)) begin
              r_idx   <= '0;
              r_state <= (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_perr  <= parity_error(PAR_MODE, w_rxs, w_word.data);
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_cnt  <= '0;
            r_idx  <= r_idx + 3'd1;
            r_ferr <= w_word.ferr;
            if (w_push) r_state <= w_word.ferr ? ST_BREAK : ST_IDLE;
          end
        end
        ST_BREAK: begin
          r_cnt <= '0;
          if (w_rxs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_overrun <= 1'b0;
    end else if (w_overflow) begin
      r_overrun <= 1'b1;
    end else if (ovr_clr_i) begin
      r_overrun <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(rx_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_wr_en    (w_push),
    .i_wr_data  (w_word),
    .i_rd_en    (rx_ready_i),
    .o_rd_data  (w_head),
    .o_valid    (rx_valid_o),
    .o_level    (rx_level_o),
    .o_overflow (w_overflow)
  );

  assign rx_byte_o = w_head.data[DATA_BITS-1:0];
  assign rx_perr_o = w_head.perr;
  assign rx_ferr_o = w_head.ferr;
  assign overrun_o = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized bench for uart_rx_fifo: three instances (8N1 depth 4,
// 7E1 depth 8, 8N2 depth 8) checked against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int CCS = 16;

  logic clk;
  logic rst;
  logic rx    [3];
  logic ready [3];
  logic clr   [3];

  logic [7:0] byte_a;
  logic [6:0] byte_b;
  logic [7:0] byte_c;
  logic [2:0] level_a;
  logic [3:0] level_b;
  logic [3:0] level_c;
  logic       perr_a, perr_b, perr_c;
  logic       ferr_a, ferr_b, ferr_c;
  logic       valid_a, valid_b, valid_c;
  logic       ovr_a, ovr_b, ovr_c;

  logic [7:0] o_byte  [3];
  int         o_level [3];
  logic       o_perr  [3];
  logic       o_ferr  [3];
  logic       o_valid [3];
  logic       o_ovr   [3];

  int dep [3] = '{4, 8, 8};
  int nb  [3] = '{8, 7, 8};
  int nst [3] = '{1, 1, 2};

  typedef struct {
    int         ch;
    logic [7:0] d;
    logic       p;
    logic       f;
  } ent_t;

  ent_t mq [$];
  bit   m_ovr [3];
  int   n_assert;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fifo #(.CCS_PER_BIT(CCS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx[0]), .rx_byte_o(byte_a), .rx_perr_o(perr_a),
    .rx_ferr_o(ferr_a), .rx_valid_o(valid_a), .rx_ready_i(ready[0]), .rx_level_o(level_a),
    .overrun_o(ovr_a), .ovr_clr_i(clr[0])
  );

  uart_rx_fifo #(.CCS_PER_BIT(CCS), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(8)) dut_b (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx[1]), .rx_byte_o(byte_b), .rx_perr_o(perr_b),
    .rx_ferr_o(ferr_b), .rx_valid_o(valid_b), .rx_ready_i(ready[1]), .rx_level_o(level_b),
    .overrun_o(ovr_b), .ovr_clr_i(clr[1])
  );

  uart_rx_fifo #(.CCS_PER_BIT(CCS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(8)) dut_c (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx[2]), .rx_byte_o(byte_c), .rx_perr_o(perr_c),
    .rx_ferr_o(ferr_c), .rx_valid_o(valid_c), .rx_ready_i(ready[2]), .rx_level_o(level_c),
    .overrun_o(ovr_c), .ovr_clr_i(clr[2])
  );

  always_comb begin
    o_byte[0]  = byte_a;           o_byte[1]  = {1'b0, byte_b};   o_byte[2]  = byte_c;
    o_level[0] = int'(level_a);    o_level[1] = int'(level_b);    o_level[2] = int'(level_c);
    o_perr[0]  = perr_a;           o_perr[1]  = perr_b;           o_perr[2]  = perr_c;
    o_ferr[0]  = ferr_a;           o_ferr[1]  = ferr_b;           o_ferr[2]  = ferr_c;
    o_valid[0] = valid_a;          o_valid[1] = valid_b;          o_valid[2] = valid_c;
    o_ovr[0]   = ovr_a;            o_ovr[1]   = ovr_b;            o_ovr[2]   = ovr_c;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_head(input int ch);
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].ch == ch) return i;
    end
    return -1;
  endfunction

  function automatic int m_level(input int ch);
    int n;
    n = 0;
    foreach (mq[i]) if (mq[i].ch == ch) n++;
    return n;
  endfunction

  function automatic void m_pop(input int ch);
    int h;
    h = m_head(ch);
    if (h >= 0) mq.delete(h);
  endfunction

  function automatic void m_push(input int ch, input logic [7:0] d, input logic p, input logic f);
    ent_t e;
    if (m_level(ch) == dep[ch]) begin
      m_ovr[ch] = 1'b1;
    end else begin
      e.ch = ch; e.d = d; e.p = p; e.f = f;
      mq.push_back(e);
    end
  endfunction

  task automatic check_state(input int ch, input string tag);
    int h;
    h = m_head(ch);
    chk($sformatf("%s.ch%0d.valid", tag, ch), int'(o_valid[ch]), int'(h >= 0));
    chk($sformatf("%s.ch%0d.level", tag, ch), o_level[ch], m_level(ch));
    chk($sformatf("%s.ch%0d.overrun", tag, ch), int'(o_ovr[ch]), int'(m_ovr[ch]));
    if (h >= 0) begin
      chk($sformatf("%s.ch%0d.byte", tag, ch), int'(o_byte[ch]), int'(mq[h].d));
      chk($sformatf("%s.ch%0d.perr", tag, ch), int'(o_perr[ch]), int'(mq[h].p));
      chk($sformatf("%s.ch%0d.ferr", tag, ch), int'(o_ferr[ch]), int'(mq[h].f));
    end
  endtask

  // Sends one frame starting at the current negedge. pbit < 0 omits the parity bit;
  // stopv[s] is the level of stop bit s. pop_at >= 0 pulses ready across the edge
  // that follows cycle pop_at of the frame.
  task automatic send_frame(input int ch, input logic [7:0] data, input int pbit,
                            input logic [1:0] stopv, input int pop_at);
    logic [15:0] fb;
    logic [7:0]  d;
    logic        p;
    logic        f;
    int          n;
    fb = '1;
    fb[0] = 1'b0;
    n = 1;
    d = 8'(data & 8'((1 << nb[ch]) - 1));
    for (int i = 0; i < nb[ch]; i++) begin
      fb[n] = d[i];
      n++;
    end
    if (pbit >= 0) begin
      fb[n] = pbit[0];
      n++;
    end
    f = 1'b0;
    for (int s = 0; s < nst[ch]; s++) begin
      fb[n] = stopv[s];
      if (!stopv[s]) f = 1'b1;
      n++;
    end
    p = (pbit >= 0) ? (pbit[0] != (^d)) : 1'b0;
    for (int c = 0; c < n * CCS; c++) begin
      rx[ch] = fb[c / CCS];
      if (c == pop_at) begin
        ready[ch] = 1'b1;
        m_pop(ch);
      end else if (pop_at >= 0 && c == pop_at + 1) begin
        ready[ch] = 1'b0;
      end
      @(negedge clk);
    end
    rx[ch] = 1'b1;
    m_push(ch, d, p, f);
    $display("frame ch%0d data %02h parity_bit %0d stops %b expect perr %0b ferr %0b", ch, d, pbit, stopv, p, f);
  endtask

  task automatic pop(input int ch);
    ready[ch] = 1'b1;
    @(negedge clk);
    ready[ch] = 1'b0;
    m_pop(ch);
    $display("pop ch%0d model level now %0d", ch, m_level(ch));
  endtask

  task automatic clear_ovr(input int ch);
    clr[ch] = 1'b1;
    @(negedge clk);
    clr[ch] = 1'b0;
    m_ovr[ch] = 1'b0;
    $display("overrun clear ch%0d", ch);
  endtask

  initial begin
    logic [7:0] d;
    int         bad;
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx[i] = 1'b1; ready[i] = 1'b0; clr[i] = 1'b0; m_ovr[i] = 1'b0;
    end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int ch = 0; ch < 3; ch++) begin
      check_state(ch, "reset");
      chk($sformatf("reset.ch%0d.byte0", ch), int'(o_byte[ch]), 0);
      chk($sformatf("reset.ch%0d.flags0", ch), int'({o_perr[ch], o_ferr[ch]}), 0);
    end

    // 8N1 basic
    send_frame(0, 8'hAB, -1, 2'b11, -1);
    check_state(0, "basic");
    chk("basic.byte_ab", int'(o_byte[0]), 8'hAB);
    pop(0);
    check_state(0, "basic_pop");

    // 7E1: correct then flipped parity bit (0x55 has four ones)
    send_frame(1, 8'h55, 0, 2'b11, -1);
    send_frame(1, 8'h55, 1, 2'b11, -1);
    check_state(1, "par_good");
    chk("par_good.perr0", int'(o_perr[1]), 0);
    pop(1);
    check_state(1, "par_bad");
    chk("par_bad.perr1", int'(o_perr[1]), 1);
    pop(1);
    check_state(1, "par_empty");

    // 8N2 with second stop bit low
    send_frame(2, 8'h5A, -1, 2'b01, -1);
    check_state(2, "frame");
    chk("frame.ferr1", int'(o_ferr[2]), 1);
    pop(2);
    check_state(2, "frame_pop");

    // Line held low for 40 bit periods: one break entry only
    rx[2] = 1'b0;
    repeat (40 * CCS) @(negedge clk);
    m_push(2, 8'h00, 1'b0, 1'b1);
    $display("break ch2 held low 40 bit periods");
    check_state(2, "break_low");
    rx[2] = 1'b1;
    repeat (3 * CCS) @(negedge clk);
    check_state(2, "break_high");
    pop(2);
    check_state(2, "break_pop");

    // Overrun on depth-4 instance
    for (int v = 1; v <= 5; v++) send_frame(0, 8'(v), -1, 2'b11, -1);
    check_state(0, "ovr");
    chk("ovr.level4", o_level[0], 4);
    chk("ovr.flag", int'(o_ovr[0]), 1);
    for (int k = 0; k < 4; k++) begin
      pop(0);
      check_state(0, "ovr_pop");
    end
    clear_ovr(0);
    check_state(0, "ovr_clr");

    // Short glitch on the line
    rx[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx[0] = 1'b1;
    repeat (3 * CCS) @(negedge clk);
    $display("glitch ch0 4 cycles low");
    check_state(0, "glitch");

    // Reset in the middle of a character with a non-empty FIFO
    send_frame(0, 8'h77, -1, 2'b11, -1);
    check_state(0, "pre_rst");
    rx[0] = 1'b0;
    repeat (CCS) @(negedge clk);
    rx[0] = 1'b1;
    repeat (CCS) @(negedge clk);
    rx[0] = 1'b0;
    repeat (CCS / 2) @(negedge clk);
    rst = 1'b1;
    rx[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    for (int i = 0; i < 3; i++) m_ovr[i] = 1'b0;
    $display("reset mid-frame ch0");
    @(negedge clk);
    check_state(0, "midrst");
    chk("midrst.byte0", int'(o_byte[0]), 0);
    repeat (2 * CCS) @(negedge clk);
    check_state(0, "midrst_idle");
    send_frame(0, 8'h3C, -1, 2'b11, -1);
    check_state(0, "after_rst");
    pop(0);

    // Full FIFO: pop on the very edge of the new push.
    // Start falls before edge 1, synchroniser +2, detection +1, half bit +8,
    // then 9 full bits to the stop sample: push edge 155, so ready is raised at cycle 154.
    for (int k = 0; k < 4; k++) send_frame(0, 8'($urandom_range(0, 255)), -1, 2'b11, -1);
    check_state(0, "coll_full");
    d = 8'($urandom_range(0, 255));
    send_frame(0, d, -1, 2'b11, 154);
    check_state(0, "coll");
    chk("coll.level4", o_level[0], 4);
    chk("coll.no_ovr", int'(o_ovr[0]), 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) chk("coll.tail", int'(o_byte[0]), int'(d));
      pop(0);
      check_state(0, "coll_pop");
    end

    // Randomized traffic with random pops on the 8N1 instance
    for (int k = 0; k < 12; k++) begin
      send_frame(0, 8'($urandom_range(0, 255)), -1, 2'b11, -1);
      check_state(0, "rnd_a");
      repeat ($urandom_range(0, 2)) begin
        pop(0);
        check_state(0, "rnd_a_pop");
      end
    end
    for (int k = 0; k < 6; k++) begin
      pop(0);
      check_state(0, "rnd_a_drain");
    end

    // Randomized parity correctness on the 7E1 instance
    for (int k = 0; k < 6; k++) begin
      d   = 8'($urandom_range(0, 127));
      bad = $urandom_range(0, 1);
      send_frame(1, d, int'((^d[6:0]) ^ bad[0]), 2'b11, -1);
      check_state(1, "rnd_b");
      pop(1);
      check_state(1, "rnd_b_pop");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
